// File: rtl/nn_engine.sv
// nn_engine: loads up to 9 signed weights, then runs a strided 1-D convolution
// over byte-wide DMA reads and writes one post-processed byte per output.
// Ports: i_cfg/i_cfg_addr/i_cfg_wr_en config regs, i_start kick,
//   i_dma_rd_* / o_dma_rd_* read port, o_dma_wr_* write port.
// Option: NN_SATURATE_EN clamps results to DW bits; otherwise they wrap.
module nn_engine #(
  parameter int DW   = 8,
  parameter int AW   = 5,
  parameter int ACCW = 24
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [15:0]   i_cfg,
  input  logic [1:0]    i_cfg_addr,
  input  logic          i_cfg_wr_en,
  input  logic          i_start,
  input  logic [DW-1:0] i_dma_rd_data,
  input  logic          i_dma_rd_ready,
  output logic [AW-1:0] o_dma_wr_addr,
  output logic          o_dma_wr_en,
  output logic [DW-1:0] o_dma_wr_data,
  output logic          o_dma_rd_en,
  output logic [AW-1:0] o_dma_rd_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_W,
    S_READ_X,
    S_WRITE
  } state_t;

  localparam int PW = 2 * DW;

  state_t state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [5:0] o_q, o_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] w_q [9];
  logic signed [DW-1:0] w_d [9];

  logic [1:0] mode_q, mode_d;
  logic [1:0] stride_q, stride_d;
  logic relu_q, relu_d;
  logic [2:0] shift_q, shift_d;
  logic [AW-1:0] wr_base_q, wr_base_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic [AW-1:0] wgt_base_q, wgt_base_d;
  logic [5:0] cnt_q, cnt_d;
  logic signed [15:0] bias_q, bias_d;

  logic rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;

  logic [3:0] taps;
  logic [AW-1:0] step;
  logic [AW-1:0] o_off;
  logic last_tap;
  logic last_out;
  logic signed [PW-1:0] mul;
  logic signed [ACCW-1:0] acc_n;
  logic signed [ACCW-1:0] r_sum;
  logic signed [ACCW-1:0] r_sh;
  logic signed [ACCW-1:0] r_rl;
  logic [DW-1:0] res;

  always_comb begin
    case (mode_q)
      2'd0:    taps = 4'd1;
      2'd1:    taps = 4'd3;
      2'd2:    taps = 4'd6;
      default: taps = 4'd9;
    endcase
    step = (stride_q == 2'd0) ? AW'(1)
                              : {{(AW-2){1'b0}}, stride_q};
    last_tap = (k_q == taps - 4'd1);
    // out_count 0 wraps to 63 here, giving 64 outputs
    last_out = (o_q == cnt_q - 6'd1);
  end

  // Result path: acc_n is the accumulator including the current beat
  always_comb begin
    mul   = w_q[k_q] * $signed(i_dma_rd_data);
    acc_n = acc_q + {{(ACCW-PW){mul[PW-1]}}, mul};
    r_sum = acc_n + {{(ACCW-16){bias_q[15]}}, bias_q};
    r_sh  = r_sum >>> shift_q;
    r_rl  = (relu_q && r_sh[ACCW-1]) ? '0 : r_sh;
  end

`ifdef NN_SATURATE_EN
  localparam logic signed [ACCW-1:0] SAT_HI = ACCW'((1 << (DW-1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_LO = -SAT_HI - ACCW'(1);

  always_comb begin
    if (r_rl > SAT_HI) begin
      res = SAT_HI[DW-1:0];
    end else if (r_rl < SAT_LO) begin
      res = SAT_LO[DW-1:0];
    end else begin
      res = r_rl[DW-1:0];
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^r_rl[ACCW-1:DW];
  assign res = r_rl[DW-1:0];
`endif

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    o_d        = o_q;
    acc_d      = acc_q;
    w_d        = w_q;
    mode_d     = mode_q;
    stride_d   = stride_q;
    relu_d     = relu_q;
    shift_d    = shift_q;
    wr_base_d  = wr_base_q;
    rd_base_d  = rd_base_q;
    wgt_base_d = wgt_base_q;
    cnt_d      = cnt_q;
    bias_d     = bias_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_cfg_wr_en) begin
          unique case (i_cfg_addr)
            2'd0: begin
              mode_d   = i_cfg[15:14];
              stride_d = i_cfg[13:12];
              relu_d   = i_cfg[11];
              shift_d  = i_cfg[10:8];
            end
            2'd1: begin
              wr_base_d = i_cfg[9 +: AW];
              rd_base_d = i_cfg[2 +: AW];
            end
            2'd2: begin
              wgt_base_d = i_cfg[11 +: AW];
              cnt_d      = i_cfg[5:0];
            end
            default: bias_d = i_cfg;
          endcase
        end
        if (i_start) begin
          state_d = S_LOAD_W;
          k_d     = '0;
          o_d     = '0;
        end
      end
      S_LOAD_W: begin
        if (i_dma_rd_ready) begin
          w_d[k_q] = $signed(i_dma_rd_data);
          if (last_tap) begin
            state_d = S_READ_X;
            k_d     = '0;
            acc_d   = '0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      S_READ_X: begin
        if (i_dma_rd_ready) begin
          acc_d = acc_n;
          if (last_tap) begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            wr_addr_d = wr_base_q + o_q[AW-1:0];
            wr_data_d = res;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      S_WRITE: begin
        if (last_out) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_READ_X;
          o_d     = o_q + 6'd1;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Read request is registered alongside the state it belongs to
    o_off = o_d[AW-1:0] * step;
    if (state_d == S_LOAD_W) begin
      rd_en_d   = 1'b1;
      rd_addr_d = wgt_base_d + AW'(k_d);
    end else if (state_d == S_READ_X) begin
      rd_en_d   = 1'b1;
      rd_addr_d = rd_base_d + o_off + AW'(k_d);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      o_q        <= '0;
      acc_q      <= '0;
      for (int i = 0; i < 9; i++) begin
        w_q[i] <= '0;
      end
      mode_q     <= '0;
      stride_q   <= '0;
      relu_q     <= 1'b0;
      shift_q    <= '0;
      wr_base_q  <= '0;
      rd_base_q  <= '0;
      wgt_base_q <= '0;
      cnt_q      <= '0;
      bias_q     <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      o_q        <= o_d;
      acc_q      <= acc_d;
      w_q        <= w_d;
      mode_q     <= mode_d;
      stride_q   <= stride_d;
      relu_q     <= relu_d;
      shift_q    <= shift_d;
      wr_base_q  <= wr_base_d;
      rd_base_q  <= rd_base_d;
      wgt_base_q <= wgt_base_d;
      cnt_q      <= cnt_d;
      bias_q     <= bias_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign o_dma_rd_en   = rd_en_q;
  assign o_dma_rd_addr = rd_addr_q;
  assign o_dma_wr_en   = wr_en_q;
  assign o_dma_wr_addr = wr_addr_q;
  assign o_dma_wr_data = wr_data_q;

endmodule

// File: tb/tb_nn_engine.sv
// tb_nn_engine: directed checks of nn_engine against hand-computed results.
// A small DMA memory model answers reads; a monitor logs reads and writes.
module tb_nn_engine;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [15:0] i_cfg;
  logic [1:0] i_cfg_addr;
  logic       i_cfg_wr_en;
  logic       i_start;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] o_dma_wr_addr;
  logic       o_dma_wr_en;
  logic [7:0] o_dma_wr_data;
  logic       o_dma_rd_en;
  logic [4:0] o_dma_rd_addr;

  nn_engine dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_cfg          (i_cfg),
    .i_cfg_addr     (i_cfg_addr),
    .i_cfg_wr_en    (i_cfg_wr_en),
    .i_start        (i_start),
    .i_dma_rd_data  (rd_data),
    .i_dma_rd_ready (rd_ready),
    .o_dma_wr_addr  (o_dma_wr_addr),
    .o_dma_wr_en    (o_dma_wr_en),
    .o_dma_wr_data  (o_dma_wr_data),
    .o_dma_rd_en    (o_dma_rd_en),
    .o_dma_rd_addr  (o_dma_rd_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int s0 = 0;
  bit run_on = 1'b0;
  int st_from = 0;
  int st_len = 0;
  int overlap = 0;
  int junk = 0;
  int mrel;

  logic [7:0] mem [32];
  logic [4:0] rd_q [$];
  logic [4:0] wa_q [$];
  logic [7:0] wd_q [$];
  int wc_q [$];
  int rd_at [256];

  assign rd_data = mem[o_dma_rd_addr];
  assign rd_ready = !(run_on && (cyc - s0 + 1) >= st_from
                      && (cyc - s0 + 1) < st_from + st_len);

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (run_on) begin
      mrel = cyc - s0 + 1;
      if (mrel < 256) rd_at[mrel] = o_dma_rd_en ? int'(o_dma_rd_addr) : -1;
      if (o_dma_rd_en && rd_ready) rd_q.push_back(o_dma_rd_addr);
      if (o_dma_wr_en) begin
        wa_q.push_back(o_dma_wr_addr);
        wd_q.push_back(o_dma_wr_data);
        wc_q.push_back(mrel);
      end
      if (o_dma_rd_en && o_dma_wr_en) overlap++;
      if (!o_dma_wr_en && (o_dma_wr_data != 0 || o_dma_wr_addr != 0)) junk++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wcfg(input logic [1:0] a, input logic [15:0] d);
    i_cfg_addr = a;
    i_cfg = d;
    i_cfg_wr_en = 1'b1;
    @(posedge clk);
    #1 i_cfg_wr_en = 1'b0;
  endtask

  task automatic run(input int n_wr, input int inj_at);
    rd_q.delete();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    overlap = 0;
    junk = 0;
    for (int i = 0; i < 256; i++) rd_at[i] = -1;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    s0 = cyc;
    run_on = 1'b1;
    for (int c = 1; c < 600 && wc_q.size() < n_wr; c++) begin
      if (c == inj_at) begin
        i_cfg_addr = 2'd0;
        i_cfg = 16'hD100;
        i_cfg_wr_en = 1'b1;
        i_start = 1'b1;
      end
      @(posedge clk);
      #1;
      i_cfg_wr_en = 1'b0;
      i_start = 1'b0;
    end
    repeat (2) @(negedge clk);
    run_on = 1'b0;
    chk("n_wr", wc_q.size(), n_wr);
    chk("rd_wr_overlap", overlap, 0);
    chk("wr_bus_idle_zero", junk, 0);
    chk("rd_en_after_run", o_dma_rd_en, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_cfg = '0;
    i_cfg_addr = '0;
    i_cfg_wr_en = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", o_dma_rd_en, 1'b0);
    chk("rst_rd_addr", o_dma_rd_addr, 5'd0);
    chk("rst_wr_en", o_dma_wr_en, 1'b0);
    chk("rst_wr_addr", o_dma_wr_addr, 5'd0);
    chk("rst_wr_data", o_dma_wr_data, 8'd0);
    @(posedge clk);
    #1 i_rst = 1'b0;

    // K=9, stride 1, shift 1, bias 64, all data 1
    wcfg(2'd0, 16'hD100);
    wcfg(2'd1, 16'h0004);
    wcfg(2'd2, 16'h0001);
    wcfg(2'd3, 16'd64);
    run(1, 0);
    chk("def_nrd", rd_q.size(), 18);
    for (int i = 0; i < 9; i++) begin
      chk("def_wgt_addr", rd_q[i], i);
      chk("def_x_addr", rd_q[9 + i], i + 1);
    end
    chk("def_wr_addr", wa_q[0], 5'd0);
    chk("def_wr_data", wd_q[0], 8'h24);
    chk("def_wr_cycle", wc_q[0], 19);

    // 3-cycle stall inside READ_X (k=2 at cycle 12)
    st_from = 12;
    st_len = 3;
    run(1, 0);
    st_len = 0;
    chk("stall_nrd", rd_q.size(), 18);
    chk("stall_hold12", rd_at[12], 3);
    chk("stall_hold14", rd_at[14], 3);
    chk("stall_beat15", rd_at[15], 3);
    chk("stall_next16", rd_at[16], 4);
    chk("stall_wr_data", wd_q[0], 8'h24);
    chk("stall_wr_cycle", wc_q[0], 22);

    // bias -100, shift 0: relu on then off
    wcfg(2'd3, 16'hFF9C);
    wcfg(2'd0, 16'hD800);
    run(1, 0);
    chk("relu_on_data", wd_q[0], 8'h00);
    wcfg(2'd0, 16'hD000);
    run(1, 0);
    chk("relu_off_data", wd_q[0], 8'hA5);

    // bias 1000: clamp or wrap
    wcfg(2'd3, 16'd1000);
    run(1, 0);
`ifdef NN_SATURATE_EN
    chk("sat_data", wd_q[0], 8'h7F);
`else
    chk("sat_data", wd_q[0], 8'hF1);
`endif

    // K=3, stride 2, 3 outputs, rd_base 4, wr_base 10, signed weight
    for (int i = 0; i < 32; i++) mem[i] = 8'(i + 1);
    mem[0] = 8'hFF;
    wcfg(2'd0, 16'h6000);
    wcfg(2'd1, 16'h1410);
    wcfg(2'd2, 16'h0003);
    wcfg(2'd3, 16'h0000);
    for (int pass = 0; pass < 2; pass++) begin
      // second pass pokes CFG0 and i_start while busy
      run(3, pass == 0 ? 0 : 5);
      chk("str_nrd", rd_q.size(), 12);
      for (int k = 0; k < 3; k++) chk("str_wgt_addr", rd_q[k], k);
      for (int o = 0; o < 3; o++) begin
        for (int k = 0; k < 3; k++) begin
          chk("str_x_addr", rd_q[3 + 3 * o + k], 4 + 2 * o + k);
        end
        chk("str_wr_addr", wa_q[o], 10 + o);
        chk("str_wr_cycle", wc_q[o], 7 + 4 * o);
      end
      chk("str_wr_data0", wd_q[0], 8'h1C);
      chk("str_wr_data1", wd_q[1], 8'h24);
      chk("str_wr_data2", wd_q[2], 8'h2C);
    end

    // rd_base 30, K=3: addresses wrap 30, 31, 0
    wcfg(2'd0, 16'h5000);
    wcfg(2'd1, 16'h0078);
    wcfg(2'd2, 16'h0001);
    run(1, 0);
    chk("wrap_nrd", rd_q.size(), 6);
    chk("wrap_x0", rd_q[3], 5'd30);
    chk("wrap_x1", rd_q[4], 5'd31);
    chk("wrap_x2", rd_q[5], 5'd0);
    chk("wrap_wr_data", wd_q[0], 8'h1E);
    chk("wrap_wr_cycle", wc_q[0], 7);

    // reset mid-run, then a run on the cleared config
    for (int i = 0; i < 32; i++) mem[i] = 8'h01;
    wcfg(2'd0, 16'hD100);
    wcfg(2'd1, 16'h0004);
    wcfg(2'd2, 16'h0001);
    wcfg(2'd3, 16'd64);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", o_dma_rd_en, 1'b1);
    #1 i_rst = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    chk("mrst_rd_en", o_dma_rd_en, 1'b0);
    chk("mrst_rd_addr", o_dma_rd_addr, 5'd0);
    chk("mrst_wr_en", o_dma_wr_en, 1'b0);
    repeat (3) @(negedge clk);
    chk("mrst_still_idle", o_dma_rd_en, 1'b0);
    @(posedge clk);
    #1;
    run(64, 0);
    chk("clr_nrd", rd_q.size(), 65);
    chk("clr_wgt_addr", rd_q[0], 5'd0);
    chk("clr_x_last", rd_q[64], 5'd31);
    chk("clr_wr_data", wd_q[0], 8'h01);
    chk("clr_wr_cycle0", wc_q[0], 3);
    chk("clr_wr_cycle63", wc_q[63], 129);
    chk("clr_wr_addr63", wa_q[63], 5'd31);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nn_engine.md
Name: nn_engine

Overview:
- Small neural-network MAC engine: loads up to 9 signed 8-bit weights over a byte-wide DMA read port.
- Then computes a strided 1-D convolution (dot products) over activations from the same port.
- Post-processes each result (bias, arithmetic shift, optional ReLU, clamp) and writes one byte per output over the DMA write port.
- Configured by four 16-bit registers; started by a one-cycle pulse.

Parameters:
- DW, 8, data/weight width (signed).
- AW, 5, DMA address width; addresses wrap modulo 2^AW.
- ACCW, 24, signed accumulator width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_cfg  in  16  config write data.
- i_cfg_addr  in  2  config register select.
- i_cfg_wr_en  in  1  config write strobe.
- i_start  in  1  start pulse.
- i_dma_rd_data  in  8  read data, valid in the same cycle as o_dma_rd_en.
- i_dma_rd_ready  in  1  read accepted this cycle.
- o_dma_wr_addr  out  5  write address.
- o_dma_wr_en  out  1  write strobe.
- o_dma_wr_data  out  8  write data.
- o_dma_rd_en  out  1  read request.
- o_dma_rd_addr  out  5  read address.

Interface requirements:
- One clock; reset is synchronous and active-high.
- Clock port is i_clk; reset port is i_rst.

Behaviour:
- Reset: all outputs 0, CFG0..3 = 0, FSM = IDLE, accumulator and weights cleared. Reset mid-operation aborts immediately with no further DMA activity.
- CFG0 (addr 0) fields:
  - [15:14] mode → taps K: 0→1, 1→3, 2→6, 3→9.
  - [13:12] stride; 0 is treated as 1.
  - [11] relu_en.
  - [10:8] right-shift amount.
  - [7:0] reserved.
- CFG1 (addr 1) fields: [15:9] wr_base and [8:2] rd_base (low 5 bits used); [1:0] reserved.
- CFG2 (addr 2) fields: [15:11] wgt_base; [10:6] reserved; [5:0] out_count, where 0 means 64.
- CFG3 (addr 3): signed 16-bit bias.
- Config writes take effect at the clock edge. They are ignored unless state is IDLE.
- i_start sampled in IDLE moves the FSM to LOAD_W. i_start while busy is ignored.
- FSM states:
  - IDLE.
  - LOAD_W: K reads at wgt_base+k; weight[k] captured.
  - READ_X: K reads at rd_base + o*stride + k; acc += weight[k]*x, signed.
  - WRITE: one cycle; o_dma_wr_en=1, o_dma_wr_addr = wr_base+o.
  - After WRITE: o+1 → READ_X, or → IDLE after out_count outputs.
- Each READ_X pass clears the accumulator at its start.
- Read handshake:
  - In LOAD_W/READ_X, o_dma_rd_en=1 with the address.
  - A beat completes on an edge where i_dma_rd_ready=1. If ready=0, hold en/address and stall with no state change.
- Latency: with ready always high, the first o_dma_wr_en is the (2K+1)-th cycle after the start edge. Each further output takes K+1 cycles.
- Result pipeline, computed at the last READ_X edge and registered into o_dma_wr_data:
  - r = acc_final + sign-extended bias.
  - r = r >>> shift (arithmetic).
  - If relu_en and r<0, r=0.
  - Clamp to [-128,127].
- Addresses are 5-bit and wrap modulo 32. o_dma_wr_data/addr are 0 when not writing. No read and write occur in the same cycle.

Optional Feature:
- Macro NN_SATURATE_EN.
  - Defined: final clamp to [-128,127].
  - Undefined: o_dma_wr_data = r[7:0], truncated two's-complement wrap.
- All other behaviour is identical either way.

Test Plan:
- Default case: CFG0=0xD100, CFG1=0x0004, CFG2=0x0001, CFG3=64, start; read data always 0x01, ready=1.
  - Expect 9 weight reads at addr 0..8, then 9 reads at addr 1..9.
  - Then one write at addr 0 with data 0x24 ((9+64)>>1=36), on cycle 19 after start; then IDLE.
- ReLU: same setup, CFG3=0xFF9C (bias -100), shift 0.
  - relu_en=1 → data 0x00.
  - relu_en=0 → data 0xA5 (-91).
- Saturation: CFG3=1000, shift 0.
  - With NN_SATURATE_EN → 0x7F.
  - Without → 0xF1 (1009 mod 256).
- Multi-output stride: K=3, stride 2, out_count 3, rd_base 4, wr_base 10.
  - Read addrs: 4-6, 6-8, 8-10.
  - Writes at 10, 11, 12.
  - Total 3+3*4=15 cycles.
- Stall and wrap:
  - i_dma_rd_ready low for 3 cycles mid-READ_X → en/addr held, same result, write delayed by exactly 3 cycles.
  - rd_base=30, K=3 → addrs 30, 31, 0.
- Control robustness:
  - Config write or i_start during a run → ignored, run completes unchanged.
  - i_rst high mid-run → next cycle all outputs 0, state IDLE, CFG cleared.
